// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous dmem, with optional atomic lock.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLock0 = 2'd1;
    localparam logic [1:0] StLock1 = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            prio_q, prio_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            rvalid0_q, rvalid0_d;
    logic            rvalid1_q, rvalid1_d;
    logic            lock_held;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state_q)
                StIdle: begin
                    if (req0 && req1) begin
                        gnt0 = ~prio_q;
                        gnt1 = prio_q;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                StLock0: gnt0 = req0;
                StLock1: gnt1 = req1;
                default: ;
            endcase
        end
    end

    assign mem_address = gnt1 ? addr1 : addr0;
    assign mem_data    = gnt1 ? wdata1 : wdata0;
    assign mem_wren    = (gnt0 & we0) | (gnt1 & we1);
    assign rdata       = mem_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign lock_held   = (state_q == StLock0) ? lock0 : lock1;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lock_cnt_d = lock_cnt_q;
        rvalid0_d  = gnt0 & ~we0;
        rvalid1_d  = gnt1 & ~we1;
        case (state_q)
            StIdle: begin
                if (gnt0 || gnt1) begin
`ifdef DMEM_ARB_RR_EN
                    prio_d = gnt0;
`else
                    prio_d = 1'b0;
`endif
                end
                if (gnt0 && lock0) begin
                    state_d    = StLock0;
                    lock_cnt_d = CntW'(1);
                end else if (gnt1 && lock1) begin
                    state_d    = StLock1;
                    lock_cnt_d = CntW'(1);
                end
            end
            StLock0, StLock1: begin
                // Lock budget counts every locked cycle, whether or not the owner requests.
                if (!lock_held) begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == CntW'(LOCK_MAX)) begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                    prio_d     = (state_q == StLock0);
                end else begin
                    lock_cnt_d = lock_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d    = StIdle;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            prio_q     <= 1'b0;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, then random traffic against a
// transaction-level model of ownership, lock budget, priority and a shadow memory.
module tb_dmem_port_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 8;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, req0, req1, we0, we1, lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1, mem_address;
    logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_data, mem_q;
    logic gnt0, gnt1, rvalid0, rvalid1, mem_wren;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    // Behavioural single-port synchronous dmem
    logic [DATA_W-1:0] dmem [0:(1<<ADDR_W)-1];
    always @(posedge clock) begin
        if (mem_wren) dmem[mem_address] <= mem_data;
        mem_q <= dmem[mem_address];
    end

    // Reference model: who owns the memory, when the lock began, who wins the next tie
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    int owner = -1;
    int lock_start = 0;
    int pref = 0;
    int cyc = 0;
    int pend = -1;
    logic [DATA_W-1:0] pend_data;
    bit eg0, eg1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit rst, late, r0, r1, w0, w1, l0, l1;
        logic [ADDR_W-1:0] a0, a1;
        logic [DATA_W-1:0] d0, d1;
        bit e0, e1;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(bit rst, bit late, bit r0, bit r1, bit w0, bit w1, bit l0,
                                bit l1, logic [ADDR_W-1:0] a0, logic [ADDR_W-1:0] a1,
                                logic [DATA_W-1:0] d0, logic [DATA_W-1:0] d1, bit e0, bit e1);
        vec_t v;
        v.rst = rst; v.late = late; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.l0 = l0; v.l1 = l1; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.e0 = e0; v.e1 = e1;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_grants();
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (reset) return;
        if (owner == 0) eg0 = req0;
        else if (owner == 1) eg1 = req1;
        else if (req0 && req1) begin
            eg0 = (pref == 0);
            eg1 = (pref == 1);
        end else begin
            eg0 = req0;
            eg1 = req1;
        end
    endfunction

    function automatic void model_update();
        int g;
        bit lk;
        if (reset) begin
            owner = -1;
            pref  = 0;
            pend  = -1;
        end else begin
            pend = -1;
            g = eg0 ? 0 : (eg1 ? 1 : -1);
            if (g == 0 && !we0) begin pend = 0; pend_data = shadow[addr0]; end
            if (g == 1 && !we1) begin pend = 1; pend_data = shadow[addr1]; end
            if (g == 0 && we0) shadow[addr0] = wdata0;
            if (g == 1 && we1) shadow[addr1] = wdata1;
            if (owner < 0) begin
                if (g >= 0) begin
                    pref = RR ? 1 - g : 0;
                    if ((g == 0 && lock0) || (g == 1 && lock1)) begin
                        owner      = g;
                        lock_start = cyc;
                    end
                end
            end else begin
                lk = (owner == 0) ? lock0 : lock1;
                if (!lk) owner = -1;
                else if (cyc - lock_start == LOCK_MAX) begin
                    pref  = 1 - owner;
                    owner = -1;
                end
            end
        end
        cyc++;
    endfunction

    // One clock cycle: inputs already driven; compare mid-cycle, then advance the model.
    task automatic do_cycle(bit late, bit use_tbl, bit t0, bit t1);
        #3;
        model_grants();
        if (use_tbl) begin
            check("tbl_gnt0", gnt0, t0);
            check("tbl_gnt1", gnt1, t1);
        end
        check("gnt0", gnt0, eg0);
        check("gnt1", gnt1, eg1);
        check("mem_wren", mem_wren, (eg0 & we0) | (eg1 & we1));
        if (eg0 || eg1) check("mem_address", mem_address, eg1 ? addr1 : addr0);
        if ((eg0 && we0) || (eg1 && we1)) check("mem_data", mem_data, eg1 ? wdata1 : wdata0);
        check("rvalid0", rvalid0, pend == 0);
        check("rvalid1", rvalid1, pend == 1);
        if (pend >= 0) check("rdata", rdata, pend_data);
        if (late) reset = 1'b1;
        @(posedge clock);
        model_update();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            dmem[i]   = 32'hA5A5_0000 ^ (i * 32'h0101_0107);
            shadow[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0107);
        end
        reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // rst late r0 r1 w0 w1 l0 l1 a0 a1 d0 d1 | gnt0 gnt1
        add(1, 0, 1, 1, 1, 0, 0, 0, 12'h001, 12'h002, 32'h11, 32'h22, 0, 0);
        add(1, 0, 1, 1, 1, 0, 0, 0, 12'h001, 12'h002, 32'h11, 32'h22, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 12'h010, 12'h000, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            add(0, 0, 1, 1, 0, 0, 0, 0, 12'h001, 12'h002, 0, 0,
                RR ? (k % 2 == 0) : 1'b1, RR ? (k % 2 == 1) : 1'b0);
        end
        add(0, 0, 0, 1, 0, 0, 0, 1, 12'h030, 12'h020, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 1, 0, 0, 12'h030, 12'h020, 0, 32'hDEADBEEF, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 12'h030, 12'h000, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 12'h020, 12'h000, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
        for (int k = 0; k < 1 + LOCK_MAX; k++)
            add(0, 0, 1, 1, 0, 0, 1, 0, 12'h005, 12'h006, 0, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0, 12'h005, 12'h006, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 12'h007, 12'h008, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 12'h010, 12'h000, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 12'h010, 12'h000, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0);

        @(posedge clock);
        #1;
        foreach (vecs[i]) begin
            reset = vecs[i].rst; req0 = vecs[i].r0; req1 = vecs[i].r1;
            we0 = vecs[i].w0; we1 = vecs[i].w1; lock0 = vecs[i].l0; lock1 = vecs[i].l1;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1; wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
            do_cycle(vecs[i].late, 1'b1, vecs[i].e0, vecs[i].e1);
        end

        for (int i = 0; i < 600; i++) begin
            reset  = ($urandom_range(0, 59) == 0);
            req0   = ($urandom_range(0, 9) < 6);
            req1   = ($urandom_range(0, 9) < 6);
            we0    = $urandom_range(0, 1);
            we1    = $urandom_range(0, 1);
            lock0  = ($urandom_range(0, 3) != 0) && ($urandom_range(0, 1) == 0);
            lock1  = ($urandom_range(0, 3) != 0) && ($urandom_range(0, 1) == 0);
            addr0  = ADDR_W'($urandom_range(0, 15));
            addr1  = ADDR_W'($urandom_range(0, 15));
            wdata0 = $urandom;
            wdata1 = $urandom;
            do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
